vga_mem_arbiter: RTL and testbench
==================================

Name: vga_mem_arbiter

Overview:
- Shared-memory responder on the far side of the text controller's VGA master port. It arbitrates one synchronous 16-bit RAM between the VGA master and a CPU master.
- VGA always wins. It pre-announces each access one cycle early via its access line.
- The CPU gets whatever slots are left over, through a cs/ack handshake that stalls while VGA is fetching.

Parameters:
- AW, 16, address width for both masters and the RAM.
- DW, 16, data width.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_vga_addr  in  AW  VGA address, valid when i_vga_cs is high.
- i_vga_cs  in  1  VGA read strobe; one RAM read per cycle.
- i_vga_access  in  1  VGA announces it will assert i_vga_cs in the next cycle.
- o_vga_dat  out  DW  read data, valid the cycle after i_vga_cs.
- i_cpu_addr  in  AW  CPU address.
- i_cpu_dat  in  DW  CPU write data.
- i_cpu_we  in  1  CPU write enable.
- i_cpu_cs  in  1  CPU request; held until ack.
- o_cpu_dat  out  DW  registered CPU read data.
- o_cpu_ack  out  1  one-cycle completion pulse.
- o_mem_addr  out  AW  RAM address.
- o_mem_dat  out  DW  RAM write data.
- o_mem_we  out  1  RAM write enable.
- o_mem_cs  out  1  RAM strobe.
- i_mem_dat  in  DW  RAM read data; 1-cycle latency after o_mem_cs.

Behaviour:
- RAM model: address and strobe are sampled at the edge ending cycle t. Read data is valid on i_mem_dat throughout cycle t+1. Back-to-back accesses are pipelined.
- o_vga_dat is a combinational pass-through of i_mem_dat. VGA latency is therefore exactly 1 cycle.
- r_claim is a register: r_claim <= i_vga_access. Slot t is VGA-owned if r_claim(t) or i_vga_cs(t).
- VGA slot: o_mem_cs=1, o_mem_addr=i_vga_addr, o_mem_we=0.
- CPU FSM states: IDLE, DATA, ACK.
- IDLE → DATA when all of the following hold in the same cycle:
  - i_cpu_cs=1
  - r_done=0
  - the slot is not VGA-owned

  In that cycle (issue cycle) the RAM port is driven combinationally with o_mem_cs=1, o_mem_addr=i_cpu_addr, o_mem_dat=i_cpu_dat, o_mem_we=i_cpu_we.
- If the slot is VGA-owned, the FSM stays in IDLE (stall). CPU inputs must remain stable.
- DATA: o_cpu_dat <= i_mem_dat (reads only; for writes o_cpu_dat is unchanged). Always → ACK.
- ACK: o_cpu_ack=1 for exactly this cycle; r_done <= 1; → IDLE.
- r_done clears when i_cpu_cs=0. This gives one request per cs assertion, so a cs held high after ack does not re-issue.
- Minimum CPU latency: ack appears 2 cycles after the issue cycle.
- DATA and ACK never block VGA. The pipelined RAM lets VGA issue in the cycle right after a CPU issue.
- Idle RAM port: o_mem_cs=0, o_mem_we=0, o_mem_addr=0, o_mem_dat=0.
- i_vga_cs without a preceding i_vga_access is a protocol violation. VGA still wins and a coincident CPU issue is suppressed.
- i_vga_access high on consecutive cycles blocks consecutive slots.
- Reset values: FSM=IDLE, r_claim=0, r_done=0, o_cpu_ack=0, o_cpu_dat=0. o_mem_cs and o_mem_we are then 0 unless VGA drives i_vga_cs.
- Reset mid-transaction abandons it with no ack. A write already issued to RAM stands.

Optional Feature:
- Macro VGA_ARB_STALL_CNT_EN.
- Defined: adds output port o_stall_cnt, 16 bits.
  - Saturating count of cycles in which i_cpu_cs=1, r_done=0, the FSM is in IDLE and the slot is VGA-owned.
  - Cleared by reset; holds at 16'hFFFF.
- Undefined: no port, no counter logic. Arbitration timing is identical either way.

Decomposition:
- Package vga_mem_pkg holds:
  - the FSM state encoding (IDLE=0, DATA=1, ACK=2);
  - default AW/DW constants;
  - the RAM read-latency constant (1).
- One sub-module, vga_arb_stall_cnt (saturating counter), instantiated only under VGA_ARB_STALL_CNT_EN.

Test Plan:
- CPU read, no VGA traffic: RAM[0x1234]=0xBEEF; cs at cycle 0 → o_mem_cs at cycle 0; o_cpu_ack=1 and o_cpu_dat=0xBEEF at cycle 2.
- CPU write 0x00A5→0x2000 then read back → read returns 0x00A5; exactly one o_mem_we pulse with address 0x2000.
- VGA access at cycle 4, VGA cs at cycle 5 with addr 0x1000; CPU cs at cycle 5 → VGA reads 0x1000 at cycle 5 with o_vga_dat valid at cycle 6; CPU issues at cycle 6 and acks at cycle 8; o_stall_cnt=1 if the macro is enabled.
- Text-controller pattern (access every 4 cycles, cs the following cycle) with a continuous CPU read stream → no VGA slot ever taken by the CPU; every CPU request acked exactly once.
- CPU cs held high for 10 cycles after ack → no second o_mem_cs from the CPU; dropping cs then raising it issues exactly one new access.
- i_reset asserted in the DATA state → no ack, FSM in IDLE; with cs low for one cycle and then high, a new request completes normally.

Source files
------------

// File: rtl/vga_mem_pkg.sv
// vga_mem_pkg: shared types and constants for the VGA/CPU RAM arbiter.
package vga_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, ACK = 2'd2} state_t;
  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int RD_LAT = 1;
endpackage

// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if: VGA, CPU and RAM buses seen by the arbiter.
interface vga_mem_arbiter_if import vga_mem_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic [AW-1:0] vga_addr;
  logic          vga_cs;
  logic          vga_access;
  logic [DW-1:0] vga_dat;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdat;
  logic          cpu_we;
  logic          cpu_cs;
  logic [DW-1:0] cpu_rdat;
  logic          cpu_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdat;
  logic          mem_we;
  logic          mem_cs;
  logic [DW-1:0] mem_rdat;
  modport slave (
    input  vga_addr, vga_cs, vga_access, cpu_addr, cpu_wdat, cpu_we, cpu_cs, mem_rdat,
    output vga_dat, cpu_rdat, cpu_ack, mem_addr, mem_wdat, mem_we, mem_cs
  );
  modport master (
    output vga_addr, vga_cs, vga_access, cpu_addr, cpu_wdat, cpu_we, cpu_cs, mem_rdat,
    input  vga_dat, cpu_rdat, cpu_ack, mem_addr, mem_wdat, mem_we, mem_cs
  );
endinterface

// File: rtl/vga_arb_stall_cnt.sv
// vga_arb_stall_cnt: 16-bit saturating counter of CPU stall cycles.
module vga_arb_stall_cnt (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge i_clk)
    if (i_reset) cnt <= '0;
    else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
endmodule

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one pipelined RAM between a VGA reader (always wins) and a CPU.
// Define VGA_ARB_STALL_CNT_EN to add the o_stall_cnt port.
module vga_mem_arbiter import vga_mem_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
`ifdef VGA_ARB_STALL_CNT_EN
  output logic [15:0]       o_stall_cnt,
`endif
  vga_mem_arbiter_if.slave  bus
);
  state_t        state, state_n;
  logic          r_claim, r_done, we_q, vga_owned, issue;
  logic [DW-1:0] rdat_q;
  always_comb begin
    vga_owned = r_claim | bus.vga_cs;
    issue     = state == IDLE && bus.cpu_cs && !r_done && !vga_owned;
    state_n   = state == IDLE ? (issue ? DATA : IDLE) : state == DATA ? ACK : IDLE;
  end
  always_ff @(posedge i_clk)
    if (i_reset) state <= IDLE;
    else state <= state_n;
  // r_done blocks re-issue until the CPU drops cs after its ack
  always_ff @(posedge i_clk)
    if (i_reset) begin
      r_claim <= 1'b0;
      r_done  <= 1'b0;
      we_q    <= 1'b0;
      rdat_q  <= '0;
    end else begin
      r_claim <= bus.vga_access;
      r_done  <= state == ACK || (r_done && bus.cpu_cs);
      if (issue) we_q <= bus.cpu_we;
      if (state == DATA && !we_q) rdat_q <= bus.mem_rdat;
    end
  assign bus.mem_cs   = bus.vga_cs | issue;
  assign bus.mem_we   = issue & bus.cpu_we;
  assign bus.mem_addr = bus.vga_cs ? bus.vga_addr : issue ? bus.cpu_addr : {AW{1'b0}};
  assign bus.mem_wdat = issue ? bus.cpu_wdat : '0;
  assign bus.vga_dat  = bus.mem_rdat;
  assign bus.cpu_rdat = rdat_q;
  assign bus.cpu_ack  = state == ACK;
`ifdef VGA_ARB_STALL_CNT_EN
  vga_arb_stall_cnt u_stall_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .inc     (state == IDLE && bus.cpu_cs && !r_done && vga_owned),
    .cnt     (o_stall_cnt)
  );
`endif
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed self-checking bench with a behavioural 1-cycle RAM.
module tb_vga_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  logic [15:0] we_addr = 16'h0;
  logic [15:0] mem [0:65535];
  logic [15:0] stall_cnt;
  vga_mem_arbiter_if #(.AW(16), .DW(16)) bus ();
  vga_mem_arbiter dut (
    .i_clk   (clk),
    .i_reset (rst),
`ifdef VGA_ARB_STALL_CNT_EN
    .o_stall_cnt (stall_cnt),
`endif
    .bus     (bus)
  );
`ifndef VGA_ARB_STALL_CNT_EN
  assign stall_cnt = 16'h0;
`endif
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.mem_cs) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdat;
      bus.mem_rdat <= mem[bus.mem_addr];
    end
  always @(negedge clk)
    if (bus.mem_we) begin
      we_cnt++;
      we_addr = bus.mem_addr;
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    #3;
    tests++;
    if ({bus.cpu_ack, bus.mem_cs, bus.mem_we, bus.mem_addr, bus.cpu_rdat} !== 35'h0) begin
      fails++;
      $display("FAIL reset_outputs got ack=%b cs=%b we=%b addr=%h rdat=%h want all 0",
               bus.cpu_ack, bus.mem_cs, bus.mem_we, bus.mem_addr, bus.cpu_rdat);
    end
`ifdef VGA_ARB_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 16'h0) begin fails++; $display("FAIL reset_stall got %h want 0", stall_cnt); end
`endif
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    step();
    bus.cpu_addr = 16'h1234; bus.cpu_we = 1'b0; bus.cpu_cs = 1'b1;
    #3;
    tests++;
    if ({bus.mem_cs, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 16'h1234}) begin
      fails++;
      $display("FAIL read_issue got cs=%b we=%b addr=%h want 1 0 1234", bus.mem_cs, bus.mem_we, bus.mem_addr);
    end
    step(); #3;
    tests++;
    if (bus.cpu_ack !== 1'b0) begin fails++; $display("FAIL read_early_ack got %b want 0", bus.cpu_ack); end
    step(); #3;
    tests++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== 16'hBEEF) begin
      fails++;
      $display("FAIL read_ack got ack=%b rdat=%h want 1 beef", bus.cpu_ack, bus.cpu_rdat);
    end
    step();
    bus.cpu_cs = 1'b0;
    #3;
    tests++;
    if (bus.cpu_ack !== 1'b0) begin fails++; $display("FAIL read_ack_pulse got %b want 0", bus.cpu_ack); end
    step();
  endtask

  task automatic test_write();
    int w0 = we_cnt;
    step();
    bus.cpu_addr = 16'h2000; bus.cpu_wdat = 16'h00A5; bus.cpu_we = 1'b1; bus.cpu_cs = 1'b1;
    #3;
    tests++;
    if ({bus.mem_cs, bus.mem_we, bus.mem_wdat} !== {1'b1, 1'b1, 16'h00A5}) begin
      fails++;
      $display("FAIL write_issue got cs=%b we=%b wdat=%h want 1 1 00a5", bus.mem_cs, bus.mem_we, bus.mem_wdat);
    end
    step();
    step(); #3;
    tests++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== 16'hBEEF) begin
      fails++;
      $display("FAIL write_ack got ack=%b rdat=%h want 1 beef", bus.cpu_ack, bus.cpu_rdat);
    end
    step();
    bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0; bus.cpu_wdat = 16'h0;
    step();
    bus.cpu_cs = 1'b1;
    step();
    step(); #3;
    tests++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== 16'h00A5) begin
      fails++;
      $display("FAIL readback got ack=%b rdat=%h want 1 00a5", bus.cpu_ack, bus.cpu_rdat);
    end
    step();
    bus.cpu_cs = 1'b0;
    step(); #3;
    tests++;
    if (we_cnt - w0 !== 1 || we_addr !== 16'h2000) begin
      fails++;
      $display("FAIL write_pulses got n=%0d addr=%h want 1 2000", we_cnt - w0, we_addr);
    end
  endtask

  task automatic test_vga_stall();
    repeat (4) step();
    bus.vga_access = 1'b1;
    step();
    bus.vga_access = 1'b0; bus.vga_cs = 1'b1; bus.vga_addr = 16'h1000;
    bus.cpu_addr = 16'h1234; bus.cpu_we = 1'b0; bus.cpu_cs = 1'b1;
    #3;
    tests++;
    if ({bus.mem_cs, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 16'h1000}) begin
      fails++;
      $display("FAIL vga_slot got cs=%b we=%b addr=%h want 1 0 1000", bus.mem_cs, bus.mem_we, bus.mem_addr);
    end
    step();
    bus.vga_cs = 1'b0; bus.vga_addr = 16'h0;
    #3;
    tests++;
    if (bus.vga_dat !== 16'hCAFE || {bus.mem_cs, bus.mem_addr} !== {1'b1, 16'h1234}) begin
      fails++;
      $display("FAIL vga_then_cpu got vdat=%h cs=%b addr=%h want cafe 1 1234", bus.vga_dat, bus.mem_cs, bus.mem_addr);
    end
    step(); #3;
    tests++;
    if (bus.cpu_ack !== 1'b0) begin fails++; $display("FAIL stall_early_ack got %b want 0", bus.cpu_ack); end
    step(); #3;
    tests++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== 16'hBEEF) begin
      fails++;
      $display("FAIL stall_ack got ack=%b rdat=%h want 1 beef", bus.cpu_ack, bus.cpu_rdat);
    end
`ifdef VGA_ARB_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 16'd1) begin fails++; $display("FAIL stall_cnt1 got %0d want 1", stall_cnt); end
`endif
    step();
    bus.cpu_cs = 1'b0;
    step();
  endtask

  task automatic test_claim();
    step();
    bus.vga_access = 1'b1;
    step();
    bus.cpu_addr = 16'h4002; bus.cpu_cs = 1'b1;
    #3;
    tests++;
    if (bus.mem_cs !== 1'b0) begin fails++; $display("FAIL claim_slot1 got cs=%b want 0", bus.mem_cs); end
    step();
    bus.vga_access = 1'b0;
    #3;
    tests++;
    if (bus.mem_cs !== 1'b0) begin fails++; $display("FAIL claim_slot2 got cs=%b want 0", bus.mem_cs); end
    step(); #3;
    tests++;
    if ({bus.mem_cs, bus.mem_addr} !== {1'b1, 16'h4002}) begin
      fails++;
      $display("FAIL claim_issue got cs=%b addr=%h want 1 4002", bus.mem_cs, bus.mem_addr);
    end
    step();
    step(); #3;
    tests++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== (16'h4002 ^ 16'h5A5A)) begin
      fails++;
      $display("FAIL claim_ack got ack=%b rdat=%h want 1 %h", bus.cpu_ack, bus.cpu_rdat, 16'h4002 ^ 16'h5A5A);
    end
`ifdef VGA_ARB_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 16'd3) begin fails++; $display("FAIL stall_cnt3 got %0d want 3", stall_cnt); end
`endif
    step();
    bus.cpu_cs = 1'b0;
    step();
  endtask

  task automatic test_violation();
    step();
    bus.vga_cs = 1'b1; bus.vga_addr = 16'h1000;
    bus.cpu_addr = 16'h4003; bus.cpu_cs = 1'b1;
    #3;
    tests++;
    if ({bus.mem_cs, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 16'h1000}) begin
      fails++;
      $display("FAIL unannounced_vga got cs=%b we=%b addr=%h want 1 0 1000", bus.mem_cs, bus.mem_we, bus.mem_addr);
    end
    step();
    bus.vga_cs = 1'b0; bus.vga_addr = 16'h0;
    #3;
    tests++;
    if (bus.vga_dat !== 16'hCAFE || {bus.mem_cs, bus.mem_addr} !== {1'b1, 16'h4003}) begin
      fails++;
      $display("FAIL unannounced_next got vdat=%h cs=%b addr=%h want cafe 1 4003", bus.vga_dat, bus.mem_cs, bus.mem_addr);
    end
    step();
    step(); #3;
    tests++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== (16'h4003 ^ 16'h5A5A)) begin
      fails++;
      $display("FAIL unannounced_ack got ack=%b rdat=%h", bus.cpu_ack, bus.cpu_rdat);
    end
    step();
    bus.cpu_cs = 1'b0;
    step();
  endtask

  task automatic test_pattern();
    int viol = 0, iss = 0, acks = 0, rd_err = 0, low_left = 0;
    logic pending = 1'b0;
    logic prev_vcs = 1'b0;
    logic [15:0] prev_vaddr = 16'h0;
    logic [15:0] caddr = 16'h4010;
    for (int c = 0; c < 54; c++) begin
      step();
      if (c < 48) begin
        bus.vga_access = (c % 4 == 0);
        bus.vga_cs = (c % 4 == 1);
        bus.vga_addr = (c % 4 == 1) ? 16'h3000 + 16'(c) : 16'h0;
        if (low_left > 0) begin bus.cpu_cs = 1'b0; low_left--; end
        else begin bus.cpu_cs = 1'b1; bus.cpu_addr = caddr; end
      end else begin
        bus.vga_access = 1'b0; bus.vga_cs = 1'b0; bus.vga_addr = 16'h0;
        bus.cpu_cs = pending;
      end
      #3;
      if (bus.vga_cs && (bus.mem_addr !== bus.vga_addr || bus.mem_we !== 1'b0 || bus.mem_cs !== 1'b1)) viol++;
      if (prev_vcs && bus.vga_dat !== (prev_vaddr ^ 16'h5A5A)) viol++;
      if (bus.mem_cs && !bus.vga_cs) begin iss++; pending = 1'b1; end
      if (bus.cpu_ack) begin
        acks++;
        pending = 1'b0;
        if (bus.cpu_rdat !== (caddr ^ 16'h5A5A)) rd_err++;
        low_left = (acks % 2) + 1;
        caddr++;
      end
      prev_vcs = bus.vga_cs;
      prev_vaddr = bus.vga_addr;
    end
    bus.cpu_cs = 1'b0;
    step();
    tests++;
    if (viol !== 0) begin fails++; $display("FAIL pattern_vga_slots got %0d violations want 0", viol); end
    tests++;
    if (iss !== acks || acks < 8) begin
      fails++;
      $display("FAIL pattern_acks got issues=%0d acks=%0d want equal and >=8", iss, acks);
    end
    tests++;
    if (rd_err !== 0) begin fails++; $display("FAIL pattern_data got %0d errors want 0", rd_err); end
  endtask

  task automatic test_hold();
    int n = 0, a = 0;
    step();
    bus.cpu_addr = 16'h4000; bus.cpu_cs = 1'b1;
    step();
    step(); #3;
    tests++;
    if (bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== (16'h4000 ^ 16'h5A5A)) begin
      fails++;
      $display("FAIL hold_first_ack got ack=%b rdat=%h", bus.cpu_ack, bus.cpu_rdat);
    end
    for (int c = 0; c < 10; c++) begin
      step(); #3;
      if (bus.mem_cs) n++;
      if (bus.cpu_ack) a++;
    end
    tests++;
    if (n !== 0 || a !== 0) begin fails++; $display("FAIL hold_reissue got issues=%0d acks=%0d want 0 0", n, a); end
    step();
    bus.cpu_cs = 1'b0;
    step();
    bus.cpu_cs = 1'b1; bus.cpu_addr = 16'h4004;
    #3;
    tests++;
    if ({bus.mem_cs, bus.mem_addr} !== {1'b1, 16'h4004}) begin
      fails++;
      $display("FAIL hold_new_issue got cs=%b addr=%h want 1 4004", bus.mem_cs, bus.mem_addr);
    end
    n = 0; a = 0;
    for (int c = 0; c < 6; c++) begin
      step(); #3;
      if (bus.mem_cs) n++;
      if (bus.cpu_ack) a++;
    end
    tests++;
    if (n !== 0 || a !== 1) begin fails++; $display("FAIL hold_single got extra_issues=%0d acks=%0d want 0 1", n, a); end
    bus.cpu_cs = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int a = 0;
    step();
    bus.cpu_addr = 16'h4001; bus.cpu_cs = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; bus.cpu_cs = 1'b0;
    #3;
    tests++;
    if (bus.cpu_ack !== 1'b0 || bus.mem_cs !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_abandon got ack=%b cs=%b want 0 0", bus.cpu_ack, bus.mem_cs);
    end
`ifdef VGA_ARB_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 16'd0) begin fails++; $display("FAIL rst_mid_stall got %0d want 0", stall_cnt); end
`endif
    step();
    bus.cpu_cs = 1'b1;
    #3;
    tests++;
    if ({bus.mem_cs, bus.mem_addr} !== {1'b1, 16'h4001}) begin
      fails++;
      $display("FAIL rst_mid_reissue got cs=%b addr=%h want 1 4001", bus.mem_cs, bus.mem_addr);
    end
    step(); #3;
    if (bus.cpu_ack) a++;
    step(); #3;
    tests++;
    if (a !== 0 || bus.cpu_ack !== 1'b1 || bus.cpu_rdat !== (16'h4001 ^ 16'h5A5A)) begin
      fails++;
      $display("FAIL rst_mid_complete got early=%0d ack=%b rdat=%h", a, bus.cpu_ack, bus.cpu_rdat);
    end
    step();
    bus.cpu_cs = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[16'h3000 + 16'(i)] = (16'h3000 + 16'(i)) ^ 16'h5A5A;
      mem[16'h4000 + 16'(i)] = (16'h4000 + 16'(i)) ^ 16'h5A5A;
    end
    mem[16'h1234] = 16'hBEEF;
    mem[16'h1000] = 16'hCAFE;
    bus.mem_rdat = 16'h0;
    bus.vga_addr = 16'h0; bus.vga_cs = 1'b0; bus.vga_access = 1'b0;
    bus.cpu_addr = 16'h0; bus.cpu_wdat = 16'h0; bus.cpu_we = 1'b0; bus.cpu_cs = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_vga_stall();
    test_claim();
    test_violation();
    test_pattern();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
